// File: rtl/mkio_msg_framer.sv
// MKIO message framer: filters received command words by RT address, decodes the
// command fields and turns the following data words into indexed write strobes.
module mkio_msg_framer #(
  parameter logic [4:0]  RT_ADDR_A   = 5'd3,
  parameter logic [4:0]  RT_ADDR_B   = 5'd5,
  parameter bit          BCAST_EN    = 1'b1,
  parameter int unsigned GAP_TIMEOUT = 800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_done,
  input  logic [15:0] rx_data,
  input  logic        rx_cd,
  input  logic        p_error,
  output logic        cmd_valid,
  output logic        cmd_rt_sel,
  output logic        cmd_bcast,
  output logic        cmd_tr,
  output logic [4:0]  cmd_subaddr,
  output logic [5:0]  cmd_wcount,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        msg_done,
  output logic        msg_error,
  output logic [1:0]  err_code,
  output logic        busy
);

  localparam int unsigned TW = (GAP_TIMEOUT > 2) ? $clog2(GAP_TIMEOUT) : 1;

  typedef enum logic {IDLE, RX_DATA} state_t;

  state_t        state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pend_done_q, pend_done_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          cmd_rt_sel_q, cmd_rt_sel_d;
  logic          cmd_bcast_q, cmd_bcast_d;
  logic          cmd_tr_q, cmd_tr_d;
  logic [4:0]    cmd_subaddr_q, cmd_subaddr_d;
  logic [5:0]    cmd_wcount_q, cmd_wcount_d;
  logic          wr_en_q, wr_en_d;
  logic [4:0]    wr_addr_q, wr_addr_d;
  logic [15:0]   wr_data_q, wr_data_d;
  logic          msg_done_q, msg_done_d;
  logic          msg_error_q, msg_error_d;
  logic [1:0]    err_code_q, err_code_d;

  logic [4:0] dec_addr, dec_sa, dec_wc;
  logic       dec_tr, addr_hit, cmd_acc, dec_mode, dec_immed;
  logic [5:0] dec_wcount;
  logic       take_cmd, supersede;

  always_comb begin
    dec_addr   = rx_data[15:11];
    dec_tr     = rx_data[10];
    dec_sa     = rx_data[9:5];
    dec_wc     = rx_data[4:0];
    addr_hit   = (dec_addr == RT_ADDR_A) || (dec_addr == RT_ADDR_B) ||
                 (BCAST_EN && (dec_addr == 5'd31));
    cmd_acc    = rx_done && rx_cd && !p_error && addr_hit;
    dec_mode   = (dec_sa == 5'd0) || (dec_sa == 5'd31);
    dec_wcount = dec_mode ? {5'd0, (!dec_tr && dec_wc[4])}
                          : ((dec_wc == 5'd0) ? 6'd32 : {1'b0, dec_wc});
    dec_immed  = dec_tr || (dec_wcount == 6'd0);
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    timer_d       = timer_q;
    pend_done_d   = 1'b0;
    cmd_valid_d   = 1'b0;
    cmd_rt_sel_d  = cmd_rt_sel_q;
    cmd_bcast_d   = cmd_bcast_q;
    cmd_tr_d      = cmd_tr_q;
    cmd_subaddr_d = cmd_subaddr_q;
    cmd_wcount_d  = cmd_wcount_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    msg_done_d    = pend_done_q;
    msg_error_d   = 1'b0;
    err_code_d    = err_code_q;
    take_cmd      = 1'b0;
    supersede     = 1'b0;

    unique case (state_q)
      IDLE: begin
        timer_d  = '0;
        take_cmd = cmd_acc;
      end
      RX_DATA: begin
        if (rx_done) begin
          timer_d = '0;
          if (p_error) begin
            msg_error_d = 1'b1;
            err_code_d  = 2'd1;
            state_d     = IDLE;
          end else if (rx_cd) begin
            msg_error_d = 1'b1;
            err_code_d  = 2'd2;
            state_d     = IDLE;
            take_cmd    = cmd_acc;
            supersede   = 1'b1;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = idx_q;
            wr_data_d = rx_data;
            if ({1'b0, idx_q} == cmd_wcount_q - 6'd1) begin
              msg_done_d = 1'b1;
              state_d    = IDLE;
            end else begin
              idx_d = idx_q + 5'd1;
            end
          end
        end else if (timer_q == TW'(GAP_TIMEOUT - 1)) begin
          msg_error_d = 1'b1;
          err_code_d  = 2'd3;
          timer_d     = '0;
          state_d     = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A superseding command that completes immediately defers its msg_done by
    // one cycle so it never coincides with the msg_error it caused.
    if (take_cmd) begin
      cmd_valid_d   = 1'b1;
      cmd_rt_sel_d  = (dec_addr == RT_ADDR_B);
      cmd_bcast_d   = (dec_addr == 5'd31);
      cmd_tr_d      = dec_tr;
      cmd_subaddr_d = dec_sa;
      cmd_wcount_d  = dec_wcount;
      if (dec_immed) begin
        if (supersede) pend_done_d = 1'b1;
        else           msg_done_d  = 1'b1;
        state_d = IDLE;
      end else begin
        idx_d   = '0;
        timer_d = '0;
        state_d = RX_DATA;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      timer_q       <= '0;
      pend_done_q   <= 1'b0;
      cmd_valid_q   <= 1'b0;
      cmd_rt_sel_q  <= 1'b0;
      cmd_bcast_q   <= 1'b0;
      cmd_tr_q      <= 1'b0;
      cmd_subaddr_q <= '0;
      cmd_wcount_q  <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      msg_done_q    <= 1'b0;
      msg_error_q   <= 1'b0;
      err_code_q    <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      timer_q       <= timer_d;
      pend_done_q   <= pend_done_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_rt_sel_q  <= cmd_rt_sel_d;
      cmd_bcast_q   <= cmd_bcast_d;
      cmd_tr_q      <= cmd_tr_d;
      cmd_subaddr_q <= cmd_subaddr_d;
      cmd_wcount_q  <= cmd_wcount_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      msg_done_q    <= msg_done_d;
      msg_error_q   <= msg_error_d;
      err_code_q    <= err_code_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_rt_sel  = cmd_rt_sel_q;
  assign cmd_bcast   = cmd_bcast_q;
  assign cmd_tr      = cmd_tr_q;
  assign cmd_subaddr = cmd_subaddr_q;
  assign cmd_wcount  = cmd_wcount_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign msg_done    = msg_done_q;
  assign msg_error   = msg_error_q;
  assign err_code    = err_code_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mkio_msg_framer.sv
// Scoreboard bench for mkio_msg_framer: stimulus pushes expected output events,
// a negedge monitor pops and compares them, including the cycle they appear in.
module tb_mkio_msg_framer;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_done;
  logic [15:0] rx_data;
  logic        rx_cd;
  logic        p_error;
  logic        cmd_valid, cmd_rt_sel, cmd_bcast, cmd_tr;
  logic [4:0]  cmd_subaddr;
  logic [5:0]  cmd_wcount;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        msg_done, msg_error;
  logic [1:0]  err_code;
  logic        busy;

  mkio_msg_framer #(
    .RT_ADDR_A(5'd3),
    .RT_ADDR_B(5'd5),
    .BCAST_EN(1'b1),
    .GAP_TIMEOUT(800)
  ) dut (
    .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data),
    .rx_cd(rx_cd), .p_error(p_error), .cmd_valid(cmd_valid),
    .cmd_rt_sel(cmd_rt_sel), .cmd_bcast(cmd_bcast), .cmd_tr(cmd_tr),
    .cmd_subaddr(cmd_subaddr), .cmd_wcount(cmd_wcount), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .msg_done(msg_done),
    .msg_error(msg_error), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int K_CMD = 0, K_WR = 1, K_DONE = 2, K_ERR = 3;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
  } item_t;

  item_t sbq[$];
  int nassert = 0;
  int nfail   = 0;

  function automatic logic [31:0] pk(input logic rt, input logic bc, input logic tr,
                                     input logic [4:0] sa, input logic [5:0] wc);
    logic [31:0] r;
    r = '0;
    r[13] = rt; r[12] = bc; r[11] = tr; r[10:6] = sa; r[5:0] = wc;
    return r;
  endfunction

  function automatic void push(input int kind, input int c, input logic [31:0] a,
                               input logic [31:0] b);
    item_t it;
    it.kind = kind; it.cyc = c; it.a = a; it.b = b;
    sbq.push_back(it);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nassert++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic sb_check(input int kind, input logic [31:0] a, input logic [31:0] b);
    item_t it;
    nassert++;
    if (sbq.size() == 0) begin
      nfail++;
      $display("FAIL sb_unexpected: actual kind=%0d a=%h b=%h cyc=%0d, required no output",
               kind, a, b, cyc);
    end else begin
      it = sbq.pop_front();
      if (it.kind != kind || it.cyc != cyc || it.a !== a || it.b !== b) begin
        nfail++;
        $display("FAIL sb_event: actual kind=%0d cyc=%0d a=%h b=%h, required kind=%0d cyc=%0d a=%h b=%h",
                 kind, cyc, a, b, it.kind, it.cyc, it.a, it.b);
      end
    end
  endtask

  always @(negedge clk) begin
    if (msg_done || msg_error) begin
      nassert++;
      if (msg_done && msg_error) begin
        nfail++;
        $display("FAIL done_err_excl: actual both high, required at most one");
      end
    end
    if (msg_error) sb_check(K_ERR, 32'(err_code), '0);
    if (cmd_valid) sb_check(K_CMD, pk(cmd_rt_sel, cmd_bcast, cmd_tr, cmd_subaddr, cmd_wcount), '0);
    if (wr_en)     sb_check(K_WR, 32'(wr_addr), 32'(wr_data));
    if (msg_done)  sb_check(K_DONE, '0, '0);
  end

  // Word is sampled at the edge numbered e; registered outputs appear right after it.
  task automatic send(input logic [15:0] d, input logic cd, input logic pe, output int e);
    @(posedge clk); #1;
    rx_done = 1'b1; rx_data = d; rx_cd = cd; p_error = pe;
    @(posedge clk); #1;
    e = cyc;
    rx_done = 1'b0; p_error = 1'b0;
  endtask

  int e;

  initial begin
    reset = 1'b0; rx_done = 1'b0; rx_data = '0; rx_cd = 1'b0; p_error = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cmd_wcount", 32'(cmd_wcount), 0);
    chk("rst_err_code", 32'(err_code), 0);
    chk("rst_pulses", {cmd_valid, wr_en, msg_done, msg_error}, 0);
    reset = 1'b1;

    // RT3 receive, sa2, three words
    send(16'h1843, 1'b1, 1'b0, e); push(K_CMD, e, pk(0, 0, 0, 5'd2, 6'd3), '0);
    chk("t1_busy_in_msg", 32'(busy), 1);
    send(16'hAAAA, 1'b0, 1'b0, e); push(K_WR, e, 0, 32'hAAAA);
    send(16'h5555, 1'b0, 1'b0, e); push(K_WR, e, 1, 32'h5555);
    send(16'h1234, 1'b0, 1'b0, e); push(K_WR, e, 2, 32'h1234); push(K_DONE, e, '0, '0);
    chk("t1_busy_after", 32'(busy), 0);

    // RT5 transmit: completes at once
    send(16'h2C24, 1'b1, 1'b0, e); push(K_CMD, e, pk(1, 0, 1, 5'd1, 6'd4), '0); push(K_DONE, e, '0, '0);
    chk("t2_busy", 32'(busy), 0);

    // RT7 and a parity-flagged command are ignored along with the data
    send(16'h3843, 1'b1, 1'b0, e);
    for (int i = 0; i < 3; i++) send(16'h0F0F, 1'b0, 1'b0, e);
    send(16'h1843, 1'b1, 1'b1, e);
    send(16'h0F0F, 1'b0, 1'b0, e);
    chk("t3_busy", 32'(busy), 0);

    // wc=0 -> 32 words, 33rd ignored
    send(16'h1840, 1'b1, 1'b0, e); push(K_CMD, e, pk(0, 0, 0, 5'd2, 6'd32), '0);
    for (int i = 0; i < 32; i++) begin
      send(16'h0100 + 16'(i), 1'b0, 1'b0, e);
      push(K_WR, e, 32'(i), 32'h0100 + 32'(i));
    end
    push(K_DONE, e, '0, '0);
    send(16'hDEAD, 1'b0, 1'b0, e);
    chk("t4_busy", 32'(busy), 0);

    // broadcast, then mode codes (rx with wc[4] -> 1 word; tx -> 0)
    send(16'hF843, 1'b1, 1'b0, e); push(K_CMD, e, pk(0, 1, 0, 5'd2, 6'd3), '0);
    send(16'h0001, 1'b0, 1'b0, e); push(K_WR, e, 0, 32'h0001);
    send(16'h0002, 1'b0, 1'b0, e); push(K_WR, e, 1, 32'h0002);
    send(16'h0003, 1'b0, 1'b0, e); push(K_WR, e, 2, 32'h0003); push(K_DONE, e, '0, '0);
    send(16'h1811, 1'b1, 1'b0, e); push(K_CMD, e, pk(0, 0, 0, 5'd0, 6'd1), '0);
    send(16'hBEEF, 1'b0, 1'b0, e); push(K_WR, e, 0, 32'hBEEF); push(K_DONE, e, '0, '0);
    send(16'h1FE2, 1'b1, 1'b0, e); push(K_CMD, e, pk(0, 0, 1, 5'd31, 6'd0), '0); push(K_DONE, e, '0, '0);

    // parity error mid-message
    send(16'h1843, 1'b1, 1'b0, e); push(K_CMD, e, pk(0, 0, 0, 5'd2, 6'd3), '0);
    send(16'h1111, 1'b0, 1'b0, e); push(K_WR, e, 0, 32'h1111);
    send(16'h2222, 1'b0, 1'b1, e); push(K_ERR, e, 1, '0);
    send(16'h3333, 1'b0, 1'b0, e);
    chk("t5_err_code_held", 32'(err_code), 1);

    // gap timeout: error lands 800 edges after the last word
    send(16'h1843, 1'b1, 1'b0, e); push(K_CMD, e, pk(0, 0, 0, 5'd2, 6'd3), '0);
    send(16'h4444, 1'b0, 1'b0, e); push(K_WR, e, 0, 32'h4444); push(K_ERR, e + 800, 3, '0);
    repeat (790) @(posedge clk);
    #1 chk("t6_busy_before_expiry", 32'(busy), 1);
    repeat (15) @(posedge clk);
    #1 chk("t6_busy_after_expiry", 32'(busy), 0);

    // superseding command: error with cmd_valid, deferred done
    send(16'h1843, 1'b1, 1'b0, e); push(K_CMD, e, pk(0, 0, 0, 5'd2, 6'd3), '0);
    send(16'h5555, 1'b0, 1'b0, e); push(K_WR, e, 0, 32'h5555);
    send(16'h2C24, 1'b1, 1'b0, e);
    push(K_ERR, e, 2, '0); push(K_CMD, e, pk(1, 0, 1, 5'd1, 6'd4), '0); push(K_DONE, e + 1, '0, '0);
    repeat (3) @(posedge clk);
    #1 chk("t7_err_code", 32'(err_code), 2);

    // reset mid-message drops it silently
    send(16'h1843, 1'b1, 1'b0, e); push(K_CMD, e, pk(0, 0, 0, 5'd2, 6'd3), '0);
    send(16'h6666, 1'b0, 1'b0, e); push(K_WR, e, 0, 32'h6666);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    chk("t8_busy", 32'(busy), 0);
    chk("t8_err_code", 32'(err_code), 0);
    chk("t8_wr_addr", 32'(wr_addr), 0);
    send(16'h7777, 1'b0, 1'b0, e);

    repeat (5) @(posedge clk);
    #1 chk("sb_drained", 32'(sbq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
